// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
// State codes, status-word bit positions and counter sizing.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int STS_DOM_LSB    = 0;
    localparam int STS_STATE_LSB  = 16;
    localparam int STS_TRIG_GATE  = 19;
    localparam int STS_TRIG_S     = 20;
    localparam int STS_WDOG_S     = 21;
    localparam int STS_INST_S     = 22;
    localparam int STS_WDOG_FAULT = 23;
    localparam int STS_INST_FAULT = 24;

    function automatic int clog2(input longint v);
        int r;
        r = 0;
        for (int i = 0; i < 62; i++) begin
            if ((longint'(1) << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int cnt_width(input longint n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_bits.sv
// Multi-stage synchroniser for asynchronous pin inputs.
// Every bit gets its own independent flop chain.
module sync_bits #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release, trigger gating, watchdog/instant kill
// and heartbeat for the downstream peripheral reset domains.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS         = 6,
    parameter int RELEASE_GAP_CYCLES  = 16,
    parameter int WDOG_TIMEOUT_CYCLES = 1250000,
    parameter int ALIVE_LOW_CYCLES    = 12500000,
    parameter int ALIVE_HIGH_CYCLES   = 1250000,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                   clk,
    input  logic                   peripheral_aresetn,
    input  logic                   cfg_trigger_mode,
    input  logic                   cfg_ext_trigger,
    input  logic                   cfg_int_trigger_en,
    input  logic                   cfg_wdog_en,
    input  logic                   cfg_instant_en,
    input  logic [NUM_DOMAINS-1:0] cfg_trig_mask,
    input  logic                   counter_trigger,
    input  logic                   trigger_in,
    input  logic                   watchdog_in,
    input  logic                   instant_reset_in,
    output logic [NUM_DOMAINS-1:0] domain_aresetn,
    output logic                   master_trigger_out,
    output logic                   alive_signal_out,
    output logic                   reset_ack_out,
    output logic [31:0]            sts
);

    localparam int GAP_W   = cnt_width(RELEASE_GAP_CYCLES);
    localparam int WDOG_W  = cnt_width(WDOG_TIMEOUT_CYCLES);
    localparam int ALIVE_P = ALIVE_LOW_CYCLES + ALIVE_HIGH_CYCLES;
    localparam int ALIVE_W = cnt_width(ALIVE_P);
    localparam int IDX_W   = cnt_width(NUM_DOMAINS);

    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(RELEASE_GAP_CYCLES - 1);
    localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_TIMEOUT_CYCLES - 1);
    localparam logic [ALIVE_W-1:0] ALIVE_LAST = ALIVE_W'(ALIVE_P - 1);
    localparam logic [ALIVE_W-1:0] ALIVE_LOW  = ALIVE_W'(ALIVE_LOW_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);

    // Asynchronous assert, synchronous deassert of the internal reset.
    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) rst_pipe <= '0;
        else                     rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    logic [2:0] pin_s;
    logic       trig_s;
    logic       wdog_s;
    logic       inst_s;

    sync_bits #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({instant_reset_in, watchdog_in, trigger_in}),
        .q     (pin_s)
    );

    assign trig_s = pin_s[0];
    assign wdog_s = pin_s[1];
    assign inst_s = pin_s[2];

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [GAP_W-1:0]       gap_cnt;
    logic [NUM_DOMAINS-1:0] released;
    logic                   wdog_fault;
    logic                   inst_fault;
    logic [WDOG_W-1:0]      wdog_cnt;
    logic                   wdog_prev;
    logic                   trig_gate;
    logic [ALIVE_W-1:0]     alive_cnt;

    logic wdog_edge;
    logic wdog_timeout;
    logic inst_hit;
    logic fault_exit;

    assign wdog_edge    = wdog_s ^ wdog_prev;
    assign wdog_timeout = cfg_wdog_en && (state == RUN) && (wdog_cnt == WDOG_LAST);
    assign inst_hit     = cfg_instant_en && inst_s;
    // Both recorded causes must be cleared before leaving FAULT.
    assign fault_exit   = (!wdog_fault || !cfg_wdog_en)
                       && (!inst_fault || !inst_s || !cfg_instant_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HOLD;
            idx        <= '0;
            gap_cnt    <= '0;
            released   <= '0;
            wdog_fault <= 1'b0;
            inst_fault <= 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    state   <= RELEASE;
                    idx     <= '0;
                    gap_cnt <= '0;
                end
                RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        released[idx] <= 1'b1;
                        gap_cnt       <= '0;
                        if (idx == IDX_LAST) state <= RUN;
                        else                 idx   <= idx + 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (wdog_timeout || inst_hit) begin
                        state      <= FAULT;
                        wdog_fault <= wdog_timeout;
                        inst_fault <= inst_hit;
                    end
                end
                FAULT: begin
                    if (fault_exit) begin
                        state      <= RUN;
                        wdog_fault <= 1'b0;
                        inst_fault <= 1'b0;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            wdog_prev <= 1'b0;
        end else begin
            wdog_prev <= wdog_s;
            if (wdog_edge || !cfg_wdog_en || state != RUN) wdog_cnt <= '0;
            else if (wdog_cnt != WDOG_LAST)                wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_gate          <= 1'b0;
            master_trigger_out <= 1'b0;
            reset_ack_out      <= 1'b0;
            domain_aresetn     <= '0;
        end else begin
            trig_gate <= cfg_ext_trigger ? trig_s
                                         : (cfg_int_trigger_en & counter_trigger);
            master_trigger_out <= cfg_int_trigger_en & counter_trigger;
            reset_ack_out      <= (state == FAULT);
            domain_aresetn     <= released
                & ~(cfg_trig_mask & ({NUM_DOMAINS{state == FAULT}}
                | {NUM_DOMAINS{cfg_trigger_mode & ~trig_gate}}));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_cnt        <= '0;
            alive_signal_out <= 1'b0;
        end else begin
            alive_cnt        <= (alive_cnt == ALIVE_LAST) ? '0 : alive_cnt + 1'b1;
            alive_signal_out <= (alive_cnt >= ALIVE_LOW);
        end
    end

    always_comb begin
        sts = '0;
        sts[STS_DOM_LSB +: NUM_DOMAINS] = domain_aresetn;
        sts[STS_STATE_LSB +: 3]         = {1'b0, state};
        sts[STS_TRIG_GATE]              = trig_gate;
        sts[STS_TRIG_S]                 = trig_s;
        sts[STS_WDOG_S]                 = wdog_s;
        sts[STS_INST_S]                 = inst_s;
        sts[STS_WDOG_FAULT]             = wdog_fault;
        sts[STS_INST_FAULT]             = inst_fault;
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: predicted output changes
// (value and cycle) are queued by stimulus and popped by a monitor.
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int GAP  = 16;
    localparam int WDOG = 100;
    localparam int ALO  = 10;
    localparam int AHI  = 2;
    localparam int SYNC = 2;

    logic         clk = 1'b0;
    logic         peripheral_aresetn = 1'b0;
    logic         cfg_trigger_mode = 1'b0;
    logic         cfg_ext_trigger = 1'b0;
    logic         cfg_int_trigger_en = 1'b1;
    logic         cfg_wdog_en = 1'b0;
    logic         cfg_instant_en = 1'b0;
    logic [N-1:0] cfg_trig_mask = '0;
    logic         counter_trigger = 1'b1;
    logic         trigger_in = 1'b0;
    logic         watchdog_in = 1'b0;
    logic         instant_reset_in = 1'b0;
    logic [N-1:0] domain_aresetn;
    logic         master_trigger_out;
    logic         alive_signal_out;
    logic         reset_ack_out;
    logic [31:0]  sts;

    reset_sequencer #(
        .NUM_DOMAINS         (N),
        .RELEASE_GAP_CYCLES  (GAP),
        .WDOG_TIMEOUT_CYCLES (WDOG),
        .ALIVE_LOW_CYCLES    (ALO),
        .ALIVE_HIGH_CYCLES   (AHI),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .clk                (clk),
        .peripheral_aresetn (peripheral_aresetn),
        .cfg_trigger_mode   (cfg_trigger_mode),
        .cfg_ext_trigger    (cfg_ext_trigger),
        .cfg_int_trigger_en (cfg_int_trigger_en),
        .cfg_wdog_en        (cfg_wdog_en),
        .cfg_instant_en     (cfg_instant_en),
        .cfg_trig_mask      (cfg_trig_mask),
        .counter_trigger    (counter_trigger),
        .trigger_in         (trigger_in),
        .watchdog_in        (watchdog_in),
        .instant_reset_in   (instant_reset_in),
        .domain_aresetn     (domain_aresetn),
        .master_trigger_out (master_trigger_out),
        .alive_signal_out   (alive_signal_out),
        .reset_ack_out      (reset_ack_out),
        .sts                (sts)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N:0] val;
        int         at;
    } ev_t;

    ev_t        q[$];
    logic [N:0] cur = '0;
    int         nvec = 0;
    int         nerr = 0;
    int         nrel = 0;
    bit         fault_m = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected domain resets from the release count and kill rules.
    function automatic logic [N-1:0] model_dom(input int nr, input logic [N-1:0] m,
                                               input bit flt, input bit md, input bit g);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++)
            r[i] = (i < nr) && !(m[i] && (flt || (md && !g)));
        return r;
    endfunction

    function automatic bit gate_model();
        return cfg_ext_trigger ? trigger_in : (cfg_int_trigger_en & counter_trigger);
    endfunction

    task automatic upd(input int lat);
        logic [N:0] v;
        v = {fault_m, model_dom(nrel, cfg_trig_mask, fault_m,
                                cfg_trigger_mode, gate_model())};
        if (v !== cur) begin
            q.push_back('{val: v, at: cyc + lat});
            cur = v;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of {ack, domains} must match the next prediction.
    initial begin
        logic [N:0] prev;
        logic [N:0] obs;
        ev_t        e;
        @(negedge clk);
        prev = {reset_ack_out, domain_aresetn};
        forever begin
            @(negedge clk);
            obs = {reset_ack_out, domain_aresetn};
            if (obs !== prev) begin
                if (q.size() == 0) begin
                    check("unexpected_change", 32'(obs), 32'(prev));
                end else begin
                    e = q.pop_front();
                    check("event_value", 32'(obs), 32'(e.val));
                    check("event_cycle", 32'(cyc), 32'(e.at));
                end
                prev = obs;
            end
        end
    end

    task automatic release_seq(input int count);
        @(negedge clk);
        peripheral_aresetn = 1'b1;
        for (int k = 1; k <= count; k++) begin
            nrel = k;
            upd(GAP + 4 + GAP * (k - 1));
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        nrel    = 0;
        fault_m = 1'b0;
        upd(1);
        peripheral_aresetn = 1'b0;
        #1;
        check("async_dom", 32'(domain_aresetn), 32'd0);
        check("async_sts", sts, 32'd0);
    endtask

    initial begin
        int hi;
        int lo;
        int t;
        bit mchk;

        step(3);
        check("rst_dom", 32'(domain_aresetn), 32'd0);
        check("rst_master", 32'(master_trigger_out), 32'd0);
        check("rst_alive", 32'(alive_signal_out), 32'd0);
        check("rst_ack", 32'(reset_ack_out), 32'd0);
        check("rst_sts", sts, 32'd0);

        release_seq(N);
        step(GAP * N + 10);
        check("sts_state_run", 32'(sts[18:16]), 32'd2);
        check("sts_dom", 32'(sts[15:0]), 32'h000F);
        check("sts_high_zero", 32'(sts[31:25]), 32'd0);

        @(negedge clk);
        cfg_trig_mask    = 4'b0101;
        cfg_trigger_mode = 1'b1;
        upd(1);
        step(8);
        @(negedge clk);
        cfg_int_trigger_en = 1'b0;
        upd(2);
        @(negedge clk);
        check("master_off", 32'(master_trigger_out), 32'd0);
        step(7);

        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            mchk = 1'b0;
            case ($urandom_range(0, 4))
                0: begin cfg_int_trigger_en = ~cfg_int_trigger_en; upd(2); mchk = 1'b1; end
                1: begin counter_trigger = ~counter_trigger; upd(2); mchk = 1'b1; end
                2: begin cfg_trig_mask = N'($urandom); upd(1); end
                3: begin trigger_in = ~trigger_in; upd(4); end
                default: begin cfg_ext_trigger = ~cfg_ext_trigger; upd(2); end
            endcase
            @(negedge clk);
            if (mchk)
                check("master_mirror", 32'(master_trigger_out),
                      32'(cfg_int_trigger_en & counter_trigger));
            step(7);
        end

        @(negedge clk);
        cfg_ext_trigger    = 1'b0;
        cfg_int_trigger_en = 1'b1;
        counter_trigger    = 1'b1;
        upd(2);
        step(8);

        @(negedge clk);
        cfg_trig_mask = N'($urandom) | 4'b0001;
        upd(1);
        cfg_wdog_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step($urandom_range(5, 60));
            watchdog_in = ~watchdog_in;
        end
        fault_m = 1'b1;
        upd(WDOG + 4);
        step(WDOG + 10);
        check("wdog_ack", 32'(reset_ack_out), 32'd1);
        check("wdog_flag", 32'(sts[23]), 32'd1);
        check("wdog_no_inst", 32'(sts[24]), 32'd0);
        @(negedge clk);
        cfg_wdog_en = 1'b0;
        fault_m     = 1'b0;
        upd(2);
        step(8);

        @(negedge clk);
        cfg_instant_en   = 1'b1;
        instant_reset_in = 1'b1;
        fault_m          = 1'b1;
        upd(4);
        step(10);
        check("inst_flag", 32'(sts[24]), 32'd1);
        check("inst_state", 32'(sts[18:16]), 32'd3);
        step(10);
        instant_reset_in = 1'b0;
        fault_m          = 1'b0;
        upd(4);
        step(8);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cfg_trig_mask    = N'($urandom);
            upd(1);
            step(4);
            instant_reset_in = 1'b1;
            fault_m          = 1'b1;
            upd(4);
            step($urandom_range(3, 25));
            instant_reset_in = 1'b0;
            fault_m          = 1'b0;
            upd(4);
            step(8);
        end

        @(negedge clk);
        cfg_trig_mask    = 4'b1010;
        upd(1);
        step(4);
        instant_reset_in = 1'b1;
        fault_m          = 1'b1;
        upd(4);
        step(10);
        cfg_instant_en = 1'b0;
        fault_m        = 1'b0;
        upd(2);
        step(5);
        instant_reset_in = 1'b0;
        step(8);
        instant_reset_in = 1'b1;
        step(20);
        instant_reset_in = 1'b0;
        step(8);
        check("inst_disabled_ack", 32'(reset_ack_out), 32'd0);

        t = 0;
        while (alive_signal_out !== 1'b0 && t < 40) begin @(negedge clk); t++; end
        t = 0;
        while (alive_signal_out !== 1'b1 && t < 40) begin @(negedge clk); t++; end
        for (int k = 0; k < 3; k++) begin
            hi = 0;
            lo = 0;
            while (alive_signal_out === 1'b1 && hi < 40) begin @(negedge clk); hi++; end
            while (alive_signal_out === 1'b0 && lo < 40) begin @(negedge clk); lo++; end
            check("alive_high", 32'(hi), AHI);
            check("alive_period", 32'(hi + lo), ALO + AHI);
        end

        assert_reset();
        check("async_alive", 32'(alive_signal_out), 32'd0);
        check("async_master", 32'(master_trigger_out), 32'd0);
        step(5);
        release_seq(2);
        step(2 * GAP + 9);
        assert_reset();
        step(5);
        release_seq(N);
        step(GAP * N + 10);
        check("rerun_state", 32'(sts[18:16]), 32'd2);

        step(5);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised reset/trigger manager for N downstream reset domains (ADC writer, DAC synth, PDM, XADC, BRAM, …).
- On power-up, releases domains one at a time in index order, with a programmable gap between releases.
- Gates trigger-masked domains with an internal or external trigger.
- Adds a toggle-watchdog with timeout, an instant-reset kill, a configurable alive heartbeat, and a master-trigger output.
- Sits between the PS register bank (cfg/sts) and every peripheral's aresetn.

Parameters:
NUM_DOMAINS, 6, number of reset domains (1..16)
RELEASE_GAP_CYCLES, 16, clk cycles between consecutive domain releases (≥1)
WDOG_TIMEOUT_CYCLES, 1250000, max cycles between watchdog_in edges before fault
ALIVE_LOW_CYCLES, 12500000, heartbeat low time
ALIVE_HIGH_CYCLES, 1250000, heartbeat high time
SYNC_STAGES, 2, synchroniser depth for pin inputs (≥2)

Ports:
clk  in  1  system clock (125 MHz)
peripheral_aresetn  in  1  asynchronous active-low reset
cfg_trigger_mode  in  1  0 = continuous, 1 = trigger-gated
cfg_ext_trigger  in  1  0 = internal trigger source, 1 = trigger_in pin
cfg_int_trigger_en  in  1  internal trigger enable
cfg_wdog_en  in  1  watchdog enable
cfg_instant_en  in  1  instant-reset enable
cfg_trig_mask  in  NUM_DOMAINS  1 = domain is trigger-gated and killable
counter_trigger  in  1  sequence-counter qualifier (held high when unused)
trigger_in  in  1  external trigger pin (async)
watchdog_in  in  1  watchdog toggle pin (async)
instant_reset_in  in  1  instant-reset pin (async)
domain_aresetn  out  NUM_DOMAINS  per-domain active-low reset
master_trigger_out  out  1  trigger forwarded to slave boards
alive_signal_out  out  1  heartbeat
reset_ack_out  out  1  high while in FAULT
sts  out  32  status word

Behaviour:
- Reset is asynchronous assert, synchronous deassert: internal 2-flop reset synchroniser on peripheral_aresetn.
- While reset is asserted: all domain_aresetn = 0, master_trigger_out = 0, alive_signal_out = 0, reset_ack_out = 0, sts = 0, all counters = 0, state = HOLD.
- Pin inputs pass through SYNC_STAGES flops. Every rule below uses the synchronised copies (trig_s, wdog_s, inst_s).
- FSM states:
  - HOLD: one cycle after reset deassert, go to RELEASE, idx = 0, gap counter = 0.
  - RELEASE: released[idx] set when gap counter reaches RELEASE_GAP_CYCLES-1; then idx++ and gap counter clears. Domain 0 is released RELEASE_GAP_CYCLES cycles after entering RELEASE. After idx = NUM_DOMAINS-1 is released, go to RUN.
  - RUN: watchdog and instant checks are active.
  - FAULT: entered from RUN on watchdog timeout or (cfg_instant_en & inst_s).
    - Watchdog-caused FAULT exits to RUN when cfg_wdog_en = 0.
    - Instant-caused FAULT exits to RUN the first cycle inst_s = 0 or cfg_instant_en = 0.
- trig_gate (registered, 1-cycle latency):
  - cfg_ext_trigger = 1: trig_gate = trig_s.
  - cfg_ext_trigger = 0: trig_gate = cfg_int_trigger_en & counter_trigger.
- master_trigger_out = registered (cfg_int_trigger_en & counter_trigger). Independent of cfg_ext_trigger.
- domain_aresetn[i], registered:
  - equals released[i] & ~(mask[i] & (fault | (cfg_trigger_mode & ~trig_gate))).
  - Unmasked domains ignore triggers and faults.
- Watchdog:
  - Counter clears on any edge of wdog_s and whenever cfg_wdog_en = 0 or state ≠ RUN.
  - Timeout when counter == WDOG_TIMEOUT_CYCLES-1 with cfg_wdog_en = 1.
- reset_ack_out = (state == FAULT), registered.
- Heartbeat: free-running counter over 0..ALIVE_LOW_CYCLES+ALIVE_HIGH_CYCLES-1. Output is low for counts below ALIVE_LOW_CYCLES, high otherwise. Runs in every state except reset.
- Simultaneous watchdog timeout and instant reset: cause = instant. The watchdog-fault flag is still set; the exit condition is the AND of both cause conditions.
- cfg_trig_mask changes take effect on the next registered update. They never re-sequence released domains.
- peripheral_aresetn asserted mid-RELEASE or mid-FAULT: immediate return to the reset state, and the full sequence reruns.
- sts layout:
  - [15:0] domain_aresetn, zero-extended.
  - [18:16] state code.
  - [19] trig_gate.
  - [20] trig_s.
  - [21] wdog_s.
  - [22] inst_s.
  - [23] watchdog-fault flag.
  - [24] instant-fault flag.
  - [31:25] zero.

Decomposition:
- Package reset_sequencer_pkg holds:
  - state enum: HOLD = 0, RELEASE = 1, RUN = 2, FAULT = 3;
  - sts bit-position constants;
  - the counter width function clog2.
- Sub-module sync_bits (width, SYNC_STAGES) for the three pin synchronisers.

Test Plan:
- NUM_DOMAINS = 4, GAP = 16: deassert reset at t0 → domain_aresetn goes 0001, 0011, 0111, 1111 at exactly 16-cycle intervals; sts[18:16] = 2 after the last release.
- Trigger mode, mask = 0101, internal source, toggle cfg_int_trigger_en → domains 0 and 2 follow the trigger with 1 + registration latency; domains 1 and 3 stay 1; master_trigger_out mirrors.
- WDOG_TIMEOUT = 100, watchdog_in toggled every 50 cycles → no fault. Stop toggling → reset_ack_out = 1 and masked domains = 0 after 100 cycles. Clear cfg_wdog_en → RUN, domains restored.
- Pulse instant_reset_in for 20 cycles with cfg_instant_en = 1 → masked domains low for 20 cycles (plus sync delay). With cfg_instant_en = 0 → no effect.
- ALIVE = 10/2 → alive_signal_out has period 12, high for 2 cycles. Assert peripheral_aresetn mid-RELEASE → all outputs 0 asynchronously, and the sequence restarts from domain 0 on deassert.
